// File: rtl/key_debouncer.sv
// key_debouncer: multi-channel push-button debouncer.
// Every channel has its own 2-flop synchronizer, four-state FSM and
// stable-level counter. A level change is accepted only after it has held
// steady for DEBOUNCE_CYCLES synchronized cycles. The bank then emits a
// one-cycle press or release pulse and updates the debounced level.
// The key inputs are active-low. The outputs are active-high.
module key_debouncer #(
  parameter int KEYS            = 2,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic            clk100_i,
  input  logic            rstn_i,
  input  logic [KEYS-1:0] key_i,
  output logic [KEYS-1:0] key_press_o,
  output logic [KEYS-1:0] key_release_o,
  output logic [KEYS-1:0] key_state_o
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits suffice.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [KEYS-1:0] sync_stage1;
  logic [KEYS-1:0] key_sync;

  // Two-flop synchronizer; resets to 1 so a held key looks like a fresh press.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_stage1 <= '1;
      key_sync    <= '1;
    end else begin
      sync_stage1 <= key_i;
      key_sync    <= sync_stage1;
    end
  end

  for (genvar g = 0; g < KEYS; g++) begin : g_chan
    state_t        state;
    logic [CW-1:0] count;
    logic          press_q;
    logic          release_q;
    logic          level_q;

    // Per-channel debounce FSM with registered pulse and level outputs.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state     <= IDLE;
        count     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        level_q   <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          IDLE: begin
            if (!key_sync[g]) begin
              state <= PRESS_WAIT;
              count <= '0;
            end
          end
          PRESS_WAIT: begin
            if (key_sync[g]) begin
              state <= IDLE;
              count <= '0;
            end else if (count == LAST_COUNT) begin
              state   <= PRESSED;
              count   <= '0;
              press_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
          PRESSED: begin
            if (key_sync[g]) begin
              state <= RELEASE_WAIT;
              count <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (!key_sync[g]) begin
              state <= PRESSED;
              count <= '0;
            end else if (count == LAST_COUNT) begin
              state     <= IDLE;
              count     <= '0;
              release_q <= 1'b1;
              level_q   <= 1'b0;
            end else begin
              count <= count + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end

    assign key_press_o[g]   = press_q;
    assign key_release_o[g] = release_q;
    assign key_state_o[g]   = level_q;
  end

endmodule
